square_motion_ctrl: RTL and testbench

- Per-frame position scheduler for one rectangular sprite. It owns the sprite's top-left coordinates that feed the rectangle drawing block.
- Advances the position once per video frame by a signed velocity.
- Bounces the sprite off the screen edges.
- Freezes it for a fixed number of frames after a collision reported by the hit-detection logic.
- Sits between the frame-timing generator and the rectangle drawer.

---
 rtl/square_motion_ctrl_if.sv | 28 ++
 rtl/square_motion_ctrl.sv | 142 ++++++++++++++
 tb/tb_square_motion_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/square_motion_ctrl_if.sv
// Frame-event inputs and sprite state outputs of square_motion_ctrl.
//   startOfFrame : one-clk pulse per video frame
//   launch       : request to start motion
//   collision    : hit indication from collision logic
//   topLeftX/Y   : sprite top-left position (11-bit signed)
//   speedX/Y     : current velocity (11-bit signed)
//   state        : 0=IDLE, 1=MOVING, 2=HIT
// master = frame timing / hit logic / drawer side, slave = the controller.
interface square_motion_ctrl_if;
   logic               startOfFrame;
   logic               launch;
   logic               collision;
   logic signed [10:0] topLeftX;
   logic signed [10:0] topLeftY;
   logic signed [10:0] speedX;
   logic signed [10:0] speedY;
   logic [1:0]         state;

   modport master (
      output startOfFrame, launch, collision,
      input  topLeftX, topLeftY, speedX, speedY, state
   );

   modport slave (
      input  startOfFrame, launch, collision,
      output topLeftX, topLeftY, speedX, speedY, state
   );
endinterface

// File: rtl/square_motion_ctrl.sv
// Per-frame position scheduler for one rectangular sprite.
// Advances top-left by a signed velocity once per frame, bounces off the
// screen edges and freezes for HIT_FRAMES frames after a collision.
// Ports:
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   bus    : slave side of square_motion_ctrl_if (frame events in,
//            registered position/speed/state out)
module square_motion_ctrl #(
   parameter int OBJECT_WIDTH_X = 100,
   parameter int OBJECT_HEIGHT_Y = 100,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int INIT_X = 280,
   parameter int INIT_Y = 190,
   parameter int INIT_SPEED_X = 2,
   parameter int INIT_SPEED_Y = 3,
   parameter int HIT_FRAMES = 30
) (
   input logic clk,
   input logic resetN,
   square_motion_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVING = 2'd1,
      HIT    = 2'd2
   } state_t;

   localparam int CNT_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

   localparam logic signed [10:0] INIT_X_V  = 11'(INIT_X);
   localparam logic signed [10:0] INIT_Y_V  = 11'(INIT_Y);
   localparam logic signed [10:0] INIT_SX_V = 11'(INIT_SPEED_X);
   localparam logic signed [10:0] INIT_SY_V = 11'(INIT_SPEED_Y);
   localparam logic signed [11:0] MAX_X     = 12'(SCREEN_W - OBJECT_WIDTH_X);
   localparam logic signed [11:0] MAX_Y     = 12'(SCREEN_H - OBJECT_HEIGHT_Y);

   state_t             state_q, state_nxt;
   logic signed [10:0] x_q, x_nxt, y_q, y_nxt;
   logic signed [10:0] sx_q, sx_nxt, sy_q, sy_nxt;
   logic [CNT_W-1:0]   cnt_q, cnt_nxt;
   logic               launch_lat, coll_lat;
   logic               sof, eff_launch, eff_coll;
   logic [21:0]        mv_x, mv_y;

   // One axis of motion: returns {new_pos, new_speed}. The sum is taken at
   // 12 bits so that overshoot past either edge is seen with its true sign.
   function automatic logic [21:0] step_axis(input logic signed [10:0] pos,
                                             input logic signed [10:0] spd,
                                             input logic signed [11:0] lim);
      logic signed [11:0] nxt;
      nxt = $signed({pos[10], pos}) + $signed({spd[10], spd});
      if (nxt < 0)
         return {11'd0, 11'(-spd)};
      else if (nxt > lim)
         return {lim[10:0], 11'(-spd)};
      else
         return {nxt[10:0], spd};
   endfunction

   assign sof        = bus.startOfFrame;
   assign eff_launch = launch_lat | bus.launch;
   assign eff_coll   = coll_lat | bus.collision;
   assign mv_x       = step_axis(x_q, sx_q, MAX_X);
   assign mv_y       = step_axis(y_q, sy_q, MAX_Y);

   always_comb begin
      state_nxt = state_q;
      x_nxt     = x_q;
      y_nxt     = y_q;
      sx_nxt    = sx_q;
      sy_nxt    = sy_q;
      cnt_nxt   = cnt_q;
      case (state_q)
         IDLE: begin
            if (sof) begin
               x_nxt = INIT_X_V;
               y_nxt = INIT_Y_V;
               if (eff_launch)
                  state_nxt = MOVING;
            end
         end
         MOVING: begin
            if (sof) begin
               if (eff_coll) begin
                  state_nxt = HIT;
                  sy_nxt    = -sy_q;
                  cnt_nxt   = CNT_W'(HIT_FRAMES - 1);
               end else begin
                  {x_nxt, sx_nxt} = mv_x;
                  {y_nxt, sy_nxt} = mv_y;
               end
            end
         end
         HIT: begin
            // Leaving HIT moves in the same frame, so the entry frame plus
            // HIT_FRAMES-1 countdown frames are the frozen ones.
            if (sof) begin
               if (cnt_q == '0) begin
                  state_nxt       = MOVING;
                  {x_nxt, sx_nxt} = mv_x;
                  {y_nxt, sy_nxt} = mv_y;
               end else begin
                  cnt_nxt = cnt_q - CNT_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= IDLE;
         x_q        <= INIT_X_V;
         y_q        <= INIT_Y_V;
         sx_q       <= INIT_SX_V;
         sy_q       <= INIT_SY_V;
         cnt_q      <= '0;
         launch_lat <= 1'b0;
         coll_lat   <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         x_q        <= x_nxt;
         y_q        <= y_nxt;
         sx_q       <= sx_nxt;
         sy_q       <= sy_nxt;
         cnt_q      <= cnt_nxt;
         launch_lat <= sof ? 1'b0 : eff_launch;
         coll_lat   <= sof ? 1'b0 : eff_coll;
      end
   end

   assign bus.topLeftX = x_q;
   assign bus.topLeftY = y_q;
   assign bus.speedX   = sx_q;
   assign bus.speedY   = sy_q;
   assign bus.state    = state_q;

endmodule

// File: tb/tb_square_motion_ctrl.sv
// Directed bench for square_motion_ctrl: default instance plus a right-edge
// bounce instance and a top-left corner bounce instance.
module tb_square_motion_ctrl;

   logic clk = 1'b0;
   logic resetN = 1'b0;
   logic sof = 1'b0;
   logic launch = 1'b0;
   logic coll0 = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   square_motion_ctrl_if i0 ();
   square_motion_ctrl_if i1 ();
   square_motion_ctrl_if i2 ();

   assign i0.startOfFrame = sof;
   assign i0.launch       = launch;
   assign i0.collision    = coll0;
   assign i1.startOfFrame = sof;
   assign i1.launch       = launch;
   assign i1.collision    = 1'b0;
   assign i2.startOfFrame = sof;
   assign i2.launch       = launch;
   assign i2.collision    = 1'b0;

   square_motion_ctrl u0 (.clk(clk), .resetN(resetN), .bus(i0));
   square_motion_ctrl #(.INIT_X(538)) u1 (.clk(clk), .resetN(resetN), .bus(i1));
   square_motion_ctrl #(.INIT_X(1), .INIT_Y(1), .INIT_SPEED_X(-2), .INIT_SPEED_Y(-3))
      u2 (.clk(clk), .resetN(resetN), .bus(i2));

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_u0(input string tag, input int x, input int y,
                         input int sx, input int sy, input int st);
      check({tag, ".x"},  int'(i0.topLeftX), x);
      check({tag, ".y"},  int'(i0.topLeftY), y);
      check({tag, ".sx"}, int'(i0.speedX), sx);
      check({tag, ".sy"}, int'(i0.speedY), sy);
      check({tag, ".st"}, int'(i0.state), st);
   endtask

   // One frame pulse followed by idle cycles; returns on a falling edge.
   task automatic frame();
      @(negedge clk) sof = 1'b1;
      @(negedge clk) sof = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse_launch();
      @(negedge clk) launch = 1'b1;
      @(negedge clk) launch = 1'b0;
   endtask

   task automatic pulse_coll();
      @(negedge clk) coll0 = 1'b1;
      @(negedge clk) coll0 = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_u0("rst", 280, 190, 2, 3, 0);
      resetN = 1'b1;

      for (int i = 0; i < 3; i++) begin
         frame();
         chk_u0("idle", 280, 190, 2, 3, 0);
      end

      pulse_launch();
      frame();
      chk_u0("f1", 280, 190, 2, 3, 1);
      check("r_f1.x", int'(i1.topLeftX), 538);
      check("r_f1.st", int'(i1.state), 1);
      check("c_f1.x", int'(i2.topLeftX), 1);
      check("c_f1.y", int'(i2.topLeftY), 1);

      frame();
      chk_u0("f2", 282, 193, 2, 3, 1);
      check("r_f2.x", int'(i1.topLeftX), 540);
      check("r_f2.sx", int'(i1.speedX), 2);
      check("c_f2.x", int'(i2.topLeftX), 0);
      check("c_f2.y", int'(i2.topLeftY), 0);
      check("c_f2.sx", int'(i2.speedX), 2);
      check("c_f2.sy", int'(i2.speedY), 3);

      frame();
      chk_u0("f3", 284, 196, 2, 3, 1);
      check("r_f3.x", int'(i1.topLeftX), 540);
      check("r_f3.sx", int'(i1.speedX), -2);
      check("c_f3.x", int'(i2.topLeftX), 2);
      check("c_f3.y", int'(i2.topLeftY), 3);

      frame();
      check("r_f4.x", int'(i1.topLeftX), 538);
      check("r_f4.sx", int'(i1.speedX), -2);

      @(negedge clk) resetN = 1'b0;
      @(negedge clk) resetN = 1'b1;
      chk_u0("rst2", 280, 190, 2, 3, 0);

      pulse_launch();
      frame();
      frame();
      chk_u0("pre_hit", 282, 193, 2, 3, 1);

      pulse_coll();
      frame();
      chk_u0("hit_e", 282, 193, 2, -3, 2);

      pulse_coll();
      for (int k = 1; k < 30; k++) begin
         frame();
         chk_u0("hit_frz", 282, 193, 2, -3, 2);
      end

      frame();
      chk_u0("hit_exit", 284, 190, 2, -3, 1);

      @(negedge clk) begin
         sof   = 1'b1;
         coll0 = 1'b1;
      end
      @(negedge clk) begin
         sof   = 1'b0;
         coll0 = 1'b0;
      end
      chk_u0("hit_same", 284, 190, 2, 3, 2);

      frame();
      chk_u0("hit_same2", 284, 190, 2, 3, 2);

      @(negedge clk);
      #2 resetN = 1'b0;
      #1 chk_u0("rst_async", 280, 190, 2, 3, 0);
      @(negedge clk) resetN = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
